// File: rtl/fifo1_enq_arbiter_pkg.sv
// Shared helpers for the arbitrated Fifo1: width derivation and the
// round-robin scan used to pick the next enqueuing requester.
package fifo1_arb_pkg;

  localparam int MAXREQ = 16;
  localparam int MAXIDW = 4;

  typedef struct packed {
    logic              valid;
    logic [MAXIDW-1:0] idx;
  } pick_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // First set bit of want scanning start+1, start+2, ... wrapping, start last.
  function automatic pick_t rr_pick(input logic [MAXREQ-1:0] want,
                                    input int nreq, input int start);
    pick_t             p;
    int                i;
    logic [MAXIDW-1:0] sel;
    p = '0;
    for (int k = 1; k <= MAXREQ; k++) begin
      if (k <= nreq) begin
        i = start + k;
        if (i >= nreq) i = i - nreq;
        sel = MAXIDW'(i);
        if (!p.valid && want[sel]) begin
          p.valid = 1'b1;
          p.idx   = sel;
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fifo1_enq_arbiter_if.sv
// Requester-side enqueue bus plus consumer-side Fifo1 bus of the shared buffer.
interface fifo1_enq_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  localparam int IDW = fifo1_arb_pkg::id_width(NREQ);

  logic [NREQ-1:0]       req_want;
  logic [NREQ-1:0]       req_enq__ENA;
  logic [NREQ*WIDTH-1:0] req_enq_v;
  logic [NREQ-1:0]       req_enq__RDY;
  logic                  out_deq__ENA;
  logic                  out_deq__RDY;
  logic [WIDTH-1:0]      out_first;
  logic [IDW-1:0]        out_first_id;
  logic                  out_first__RDY;
  logic                  err;

  modport master (
    output req_want, req_enq__ENA, req_enq_v, out_deq__ENA,
    input  req_enq__RDY, out_deq__RDY, out_first, out_first_id,
           out_first__RDY, err
  );

  modport slave (
    input  req_want, req_enq__ENA, req_enq_v, out_deq__ENA,
    output req_enq__RDY, out_deq__RDY, out_first, out_first_id,
           out_first__RDY, err
  );
endinterface

// File: rtl/fifo1_enq_arbiter_pipe.sv
// Single-entry pipeline Fifo1: accepts a new word in the same cycle the old
// one is dequeued, so a continuously drained buffer moves one word per cycle.
module fifo1_pipe #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_enq__ENA,
  input  logic [W-1:0] in_enq_v,
  output logic         in_enq__RDY,
  input  logic         out_deq__ENA,
  output logic         out_deq__RDY,
  output logic [W-1:0] out_first,
  output logic         out_first__RDY
);
  logic         full;
  logic [W-1:0] element;

  assign in_enq__RDY = ~full | out_deq__ENA;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      full    <= 1'b0;
      element <= '0;
    end else if (in_enq__ENA & in_enq__RDY) begin
      element <= in_enq_v;
      full    <= 1'b1;
    end else if (out_deq__ENA & full) begin
      full <= 1'b0;
    end
  end

  assign out_deq__RDY   = full;
  assign out_first__RDY = full;
  assign out_first      = element;
endmodule

// File: rtl/fifo1_enq_arbiter.sv
// Round-robin arbiter with bounded burst lock feeding one shared Fifo1;
// each stored word is tagged with the id of the requester that wrote it.
module fifo1_enq_arbiter
  import fifo1_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int BURST = 2
) (
  input logic CLK,
  input logic RST,
  fifo1_enq_arbiter_if.slave bus
);
  localparam int IDW = id_width(NREQ);
  localparam int BCW = id_width(BURST);
  localparam logic [BCW-1:0] BMAX = BCW'(BURST - 1);

  logic [IDW-1:0]       ptr;
  logic [BCW-1:0]       bcnt;
  logic                 held;
  logic                 err_q;
  logic                 full;
  logic                 first_rdy;
  logic                 space;
  logic                 lock;
  logic                 win_valid;
  logic                 enq_fire;
  logic                 bad;
  logic [IDW-1:0]       winner;
  logic [NREQ-1:0]      rdy;
  pick_t                pick;
  logic [WIDTH-1:0]     enq_data;
  logic [WIDTH+IDW-1:0] pipe_first;

  // held marks that ptr names a real grant; right after reset ptr only seeds
  // the scan, so it must not lock requester NREQ-1 in ahead of requester 0.
  always_comb begin
    pick      = rr_pick(MAXREQ'(bus.req_want), NREQ, int'(ptr));
    lock      = held & bus.req_want[ptr] & (bcnt < BMAX);
    win_valid = lock | pick.valid;
    winner    = lock ? ptr : IDW'(pick.idx);
    rdy       = '0;
    if (space & win_valid) rdy[winner] = 1'b1;
    enq_fire  = |(bus.req_enq__ENA & rdy);
    bad       = (|(bus.req_enq__ENA & ~rdy)) | (bus.out_deq__ENA & ~full);
  end

  assign enq_data = bus.req_enq_v[winner*WIDTH +: WIDTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr   <= IDW'(NREQ - 1);
      bcnt  <= '0;
      held  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | bad;
      if (enq_fire) begin
        held <= 1'b1;
        ptr  <= winner;
        if (winner == ptr) begin
          bcnt <= (bcnt == BMAX) ? bcnt : bcnt + 1'b1;
        end else begin
          bcnt <= '0;
        end
      end
    end
  end

  fifo1_pipe #(.W(WIDTH + IDW)) u_pipe (
    .CLK            (CLK),
    .RST            (RST),
    .in_enq__ENA    (enq_fire),
    .in_enq_v       ({winner, enq_data}),
    .in_enq__RDY    (space),
    .out_deq__ENA   (bus.out_deq__ENA),
    .out_deq__RDY   (full),
    .out_first      (pipe_first),
    .out_first__RDY (first_rdy)
  );

  assign bus.req_enq__RDY   = rdy;
  assign bus.out_deq__RDY   = full;
  assign bus.out_first__RDY = first_rdy;
  assign bus.out_first      = pipe_first[WIDTH-1:0];
  assign bus.out_first_id   = pipe_first[WIDTH +: IDW];
  assign bus.err            = err_q;
endmodule
